// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit frame controller.
package uart_tx_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

endpackage

// File: rtl/uart_tx_fsm_parity_calc.sv
// Combinational parity generator: even parity when par_typ = PAR_EVEN, odd otherwise.
module parity_calc
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  assign par_bit = (^p_data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmit frame controller: start/data/parity/stop sequencing, line mux,
// and a sticky cross-check of the serializer's done flag against the bit count.
module uart_tx_fsm
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_valid,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  ser_data,
  input  logic                  ser_done,
  output logic                  ser_en,
  output logic                  busy,
  output logic                  tx_out,
  output logic                  sync_err
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic             par_bit_q;
  logic             par_en_q;
  logic             sync_err_q;
  logic             par_bit_c;
  logic             accept_c;
  logic             last_bit_c;
  logic             done_err_c;

  parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .p_data  (p_data),
    .par_typ (par_typ),
    .par_bit (par_bit_c)
  );

  assign accept_c   = data_valid && ((state == IDLE) || (state == STOP));
  assign last_bit_c = (bit_cnt == LAST_BIT);
  // Outside DATA any done pulse is wrong; inside DATA it must line up with the last bit.
  assign done_err_c = (state == DATA) ? (ser_done != last_bit_c) : ser_done;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_c) state_nxt = START;
      START:   state_nxt = DATA;
      DATA:    if (last_bit_c) state_nxt = par_en_q ? PARITY : STOP;
      PARITY:  state_nxt = STOP;
      STOP:    state_nxt = accept_c ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_cnt    <= '0;
      par_bit_q  <= 1'b0;
      par_en_q   <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      bit_cnt <= (state == DATA) ? bit_cnt + CNT_W'(1) : '0;
      if (accept_c) begin
        par_bit_q <= par_bit_c;
        par_en_q  <= par_en;
      end
      if (done_err_c) sync_err_q <= 1'b1;
    end
  end

  always_comb begin
    tx_out = 1'b1;
    busy   = 1'b1;
    ser_en = 1'b0;
    case (state)
      IDLE:    busy = 1'b0;
      START:   tx_out = 1'b0;
      DATA: begin
        ser_en = 1'b1;
        tx_out = ser_data;
      end
      PARITY:  tx_out = par_bit_q;
      STOP:    tx_out = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  assign sync_err = sync_err_q;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Directed bench for uart_tx_fsm with a behavioural serializer model.
module tb_uart_tx_fsm;
  import uart_tx_pkg::*;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         data_valid = 1'b0;
  logic [W-1:0] p_data = '0;
  logic         par_en = 1'b0;
  logic         par_typ = 1'b0;
  logic         ser_data;
  logic         ser_done;
  logic         ser_en;
  logic         busy;
  logic         tx_out;
  logic         sync_err;

  int tests = 0;
  int fails = 0;

  // Serializer model: shifts sbyte LSB first while ser_en, flags done at bit done_at.
  logic [W-1:0] sbyte = '0;
  int           sidx = 0;
  int           done_at = W - 1;

  uart_tx_fsm #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_valid (data_valid),
    .p_data     (p_data),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .ser_data   (ser_data),
    .ser_done   (ser_done),
    .ser_en     (ser_en),
    .busy       (busy),
    .tx_out     (tx_out),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst) sidx <= 0;
    else if (ser_en) sidx <= (sidx == W - 1) ? 0 : sidx + 1;
  end

  always_comb begin
    ser_data = ser_en ? sbyte[sidx[2:0]] : 1'b0;
    ser_done = ser_en && (sidx == done_at);
  end

  typedef struct {
    logic [W-1:0] data;
    logic         pe;
    logic         pt;
    int           len;
    logic [10:0]  seq;   // bit k = expected tx_out in frame cycle k
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_accept(input logic [W-1:0] d, input logic pe, input logic pt);
    data_valid = 1'b1;
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    sbyte      = d;
  endtask

  task automatic check_idle(input string tag);
    chk($sformatf("%s idle tx_out", tag), tx_out, 1'b1);
    chk($sformatf("%s idle busy", tag), busy, 1'b0);
    chk($sformatf("%s idle ser_en", tag), ser_en, 1'b0);
  endtask

  // One frame; optionally pulse data_valid with a different byte during DATA.
  task automatic run_frame(input int v, input bit poke_data);
    drive_accept(vecs[v].data, vecs[v].pe, vecs[v].pt);
    for (int k = 0; k < vecs[v].len; k++) begin
      step();
      if (k == 0) data_valid = 1'b0;
      chk($sformatf("v%0d c%0d tx_out", v, k), tx_out, vecs[v].seq[k]);
      chk($sformatf("v%0d c%0d busy", v, k), busy, 1'b1);
      chk($sformatf("v%0d c%0d ser_en", v, k), ser_en, (k >= 1 && k <= W));
      if (poke_data && k == 3) begin
        data_valid = 1'b1;
        p_data     = 8'h01;
        par_en     = 1'b0;
        par_typ    = PAR_EVEN;
      end
      if (poke_data && k == 4) data_valid = 1'b0;
    end
    step();
    check_idle($sformatf("v%0d", v));
  endtask

  initial begin
    logic [9:0] e1;
    logic [9:0] e2;

    vecs[0] = '{8'hA5, 1'b1, PAR_EVEN, 11, 11'b1_0_10100101_0};
    vecs[1] = '{8'hA5, 1'b1, PAR_ODD,  11, 11'b1_1_10100101_0};
    vecs[2] = '{8'hA5, 1'b0, PAR_EVEN, 10, 11'b1_1_10100101_0};
    vecs[3] = '{8'h3C, 1'b1, PAR_ODD,  11, 11'b1_1_00111100_0};
    vecs[4] = '{8'h01, 1'b1, PAR_EVEN, 11, 11'b1_1_00000001_0};
    vecs[5] = '{8'h80, 1'b1, PAR_ODD,  11, 11'b1_0_10000000_0};

    // Reset state
    repeat (2) step();
    check_idle("reset");
    chk("reset sync_err", sync_err, 1'b0);
    rst = 1'b1;
    step();

    for (int v = 0; v < 6; v++) run_frame(v, 1'b0);
    chk("table sync_err", sync_err, 1'b0);

    // data_valid during DATA is ignored
    run_frame(0, 1'b1);
    chk("poke sync_err", sync_err, 1'b0);

    // Back-to-back 0x00 then 0xFF, second accept in STOP
    e1 = 10'b1_00000000_0;
    e2 = 10'b1_11111111_0;
    drive_accept(8'h00, 1'b0, PAR_EVEN);
    for (int k = 0; k < 20; k++) begin
      step();
      if (k == 0 || k == 10) data_valid = 1'b0;
      chk($sformatf("b2b c%0d tx_out", k), tx_out, (k < 10) ? e1[k] : e2[k-10]);
      chk($sformatf("b2b c%0d busy", k), busy, 1'b1);
      chk($sformatf("b2b c%0d ser_en", k), ser_en,
          (k >= 1 && k <= 8) || (k >= 11 && k <= 18));
      if (k == 9) drive_accept(8'hFF, 1'b0, PAR_EVEN);
    end
    step();
    check_idle("b2b");
    chk("b2b sync_err", sync_err, 1'b0);

    // Early ser_done: DATA length unchanged, sync_err sticky
    done_at = 6;
    drive_accept(8'hA5, 1'b1, PAR_EVEN);
    for (int k = 0; k < 11; k++) begin
      step();
      if (k == 0) data_valid = 1'b0;
      chk($sformatf("early c%0d tx_out", k), tx_out, vecs[0].seq[k]);
      chk($sformatf("early c%0d ser_en", k), ser_en, (k >= 1 && k <= W));
      chk($sformatf("early c%0d sync_err", k), sync_err, (k >= 8));
    end
    step();
    check_idle("early");
    chk("early sticky sync_err", sync_err, 1'b1);
    done_at = W - 1;

    // Reset in the 4th DATA cycle, then a fresh full frame
    drive_accept(8'hA5, 1'b1, PAR_EVEN);
    for (int k = 0; k < 6; k++) begin
      step();
      if (k == 0) data_valid = 1'b0;
      if (k < 5) chk($sformatf("rstmid c%0d tx_out", k), tx_out, vecs[0].seq[k]);
      if (k == 4) rst = 1'b0;
    end
    check_idle("rstmid");
    chk("rstmid sync_err", sync_err, 1'b0);
    rst = 1'b1;
    step();
    run_frame(0, 1'b0);
    chk("rstmid final sync_err", sync_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
